// File: rtl/rvs_regfile_mp_pkg.sv
// Shared widths and types for the RVS192 integer register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rvs_regfile_mp_pkg;

  localparam int DEF_DATA_LENGTH = 32;
  localparam int DEF_REG_DEPTH   = 32;
  localparam int REG_ADDR_W      = $clog2(DEF_REG_DEPTH);

  typedef logic [REG_ADDR_W-1:0]      reg_addr_t;
  typedef logic [DEF_DATA_LENGTH-1:0] reg_data_t;

endpackage

// File: rtl/rvs_regfile_mp_if.sv
// Bundle of read, writeback and issue signals between the pipeline and the register file.
// Latency: n/a (wiring only).
// Backpressure: none; readiness is reported per read port through rd_ready.
interface rvs_regfile_mp_if #(
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int AW     = 5,
  parameter int DW     = 32
);

  logic [NUM_RD-1:0][AW-1:0] rd_addr;
  logic [NUM_RD-1:0][DW-1:0] rd_data;
  logic [NUM_RD-1:0]         rd_ready;
  logic [NUM_WR-1:0]         wr_en;
  logic [NUM_WR-1:0][AW-1:0] wr_addr;
  logic [NUM_WR-1:0][DW-1:0] wr_data;
  logic                      iss_en;
  logic [AW-1:0]             iss_rd;
  logic                      flush;

  // Pipeline side: decode drives read/issue, writeback drives writes.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
    input  rd_data, rd_ready
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
    output rd_data, rd_ready
  );

endinterface

// File: rtl/rvs_reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// Latency: state updates at posedge; rd_ready is combinational from current inputs.
// Backpressure: none; decode stalls itself on rd_ready=0.
module rvs_reg_scoreboard #(
  parameter int REG_DEPTH = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter int AW        = $clog2(REG_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iss_en,
  input  logic [AW-1:0]             iss_rd,
  input  logic                      flush,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR-1:0][AW-1:0] wr_addr,
  input  logic [NUM_RD-1:0][AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]         rd_ready
);

  logic [REG_DEPTH-1:0] pending_q;
  logic [REG_DEPTH-1:0] pending_d;

  // Next pending vector: flush clears everything, else writebacks clear and issue sets
  // (issue applied last so a newer in-flight producer keeps the register pending).
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p]) pending_d[wr_addr[p]] = 1'b0;
      end
      if (iss_en && iss_rd != '0) pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending state; reset overrides issue, writeback and flush.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // A pending register is still usable when its producer writes back this cycle,
  // because the data path bypasses that value.
  always_comb begin
    rd_ready = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_ready[i] = !pending_q[rd_addr[i]];
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && wr_addr[p] == rd_addr[i]) rd_ready[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvs_regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and RAW scoreboard.
// Latency: rd_data 0 cycles (RD_REG=0) or 1 cycle (RD_REG=1); rd_ready always combinational.
// Backpressure: none; consumers stall on rd_ready=0.
module rvs_regfile_mp
  import rvs_regfile_mp_pkg::*;
#(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int REG_DEPTH   = DEF_REG_DEPTH,
  parameter int NUM_RD      = 2,
  parameter int NUM_WR      = 1,
  parameter bit RD_REG      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  rvs_regfile_mp_if.slave   bus
);

  localparam int AW = $clog2(REG_DEPTH);

  logic [DATA_LENGTH-1:0] reg_q [REG_DEPTH];
  logic [DATA_LENGTH-1:0] reg_d [REG_DEPTH];

  // Write decode: ports applied in ascending order so the highest index wins a collision;
  // x0 is never written.
  always_comb begin
    reg_d = reg_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (bus.wr_en[p] && bus.wr_addr[p] != '0) reg_d[bus.wr_addr[p]] = bus.wr_data[p];
    end
    reg_d[0] = '0;
  end

  // Storage array; reset clears every register, overriding same-cycle writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_DEPTH; r++) reg_q[r] <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [DATA_LENGTH-1:0] byp;

    // Bypass mux: a same-cycle write to the read address is forwarded, highest port wins;
    // x0 always reads zero.
    always_comb begin
      byp = reg_q[bus.rd_addr[i]];
      for (int p = 0; p < NUM_WR; p++) begin
        if (bus.wr_en[p] && bus.wr_addr[p] == bus.rd_addr[i]) byp = bus.wr_data[p];
      end
      if (bus.rd_addr[i] == '0) byp = '0;
    end

    if (RD_REG) begin : g_reg
      logic [DATA_LENGTH-1:0] rd_data_q;
      logic [DATA_LENGTH-1:0] rd_data_d;

      // Registered read samples the bypassed value, so writes of this edge are visible.
      always_comb begin
        rd_data_d = byp;
      end

      // Read output register.
      always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
      end

      assign bus.rd_data[i] = rd_data_q;
    end else begin : g_comb
      assign bus.rd_data[i] = byp;
    end
  end

  rvs_reg_scoreboard #(
    .REG_DEPTH (REG_DEPTH),
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR),
    .AW        (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (bus.iss_en),
    .iss_rd   (bus.iss_rd),
    .flush    (bus.flush),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rd_addr  (bus.rd_addr),
    .rd_ready (bus.rd_ready)
  );

endmodule

// File: tb/tb_rvs_regfile_mp.sv
// Bench for rvs_regfile_mp: registered-read and combinational-read instances share stimulus.
// Directed scenarios with literal expectations, then randomized traffic against an array model.
// Outputs are compared on the falling edge; inputs change 2 time units after the rising edge.
module tb_rvs_regfile_mp;
  import rvs_regfile_mp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [1:0][4:0]  rd_addr;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             iss_en;
  logic [4:0]       iss_rd;
  logic             flush;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  reg_data_t regs [32];
  bit        pend [32];
  reg_data_t exp_reg [2];

  always #5 clk = ~clk;

  rvs_regfile_mp_if #(.NUM_RD(2), .NUM_WR(2), .AW(5), .DW(32)) bus_r ();
  rvs_regfile_mp_if #(.NUM_RD(2), .NUM_WR(2), .AW(5), .DW(32)) bus_c ();

  assign bus_r.rd_addr = rd_addr;  assign bus_c.rd_addr = rd_addr;
  assign bus_r.wr_en   = wr_en;    assign bus_c.wr_en   = wr_en;
  assign bus_r.wr_addr = wr_addr;  assign bus_c.wr_addr = wr_addr;
  assign bus_r.wr_data = wr_data;  assign bus_c.wr_data = wr_data;
  assign bus_r.iss_en  = iss_en;   assign bus_c.iss_en  = iss_en;
  assign bus_r.iss_rd  = iss_rd;   assign bus_c.iss_rd  = iss_rd;
  assign bus_r.flush   = flush;    assign bus_c.flush   = flush;

  rvs_regfile_mp #(.DATA_LENGTH(32), .REG_DEPTH(32), .NUM_RD(2), .NUM_WR(2), .RD_REG(1'b1))
    dut_r (.clk(clk), .rst(rst), .bus(bus_r));
  rvs_regfile_mp #(.DATA_LENGTH(32), .REG_DEPTH(32), .NUM_RD(2), .NUM_WR(2), .RD_REG(1'b0))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural read: x0 is zero, a same-cycle write is seen (last port wins), else the array.
  function automatic reg_data_t model_rd(input logic [4:0] a);
    reg_data_t v;
    if (a == 5'd0) return '0;
    v = regs[a];
    for (int p = 0; p < 2; p++) if (wr_en[p] && wr_addr[p] == a) v = wr_data[p];
    return v;
  endfunction

  function automatic bit model_rdy(input logic [4:0] a);
    bit hit = 1'b0;
    for (int p = 0; p < 2; p++) if (wr_en[p] && wr_addr[p] == a) hit = 1'b1;
    return !pend[a] || hit;
  endfunction

  // Model state update at each rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) exp_reg[i] = rst ? 32'd0 : model_rd(rd_addr[i]);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin regs[r] = '0; pend[r] = 1'b0; end
    end else begin
      for (int p = 0; p < 2; p++) if (wr_en[p] && wr_addr[p] != 5'd0) regs[wr_addr[p]] = wr_data[p];
      if (flush) begin
        for (int r = 0; r < 32; r++) pend[r] = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) if (wr_en[p]) pend[wr_addr[p]] = 1'b0;
        if (iss_en && iss_rd != 5'd0) pend[iss_rd] = 1'b1;
      end
    end
  end

  // Compare process: every output of both instances against the model, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("rd_data_comb",  bus_c.rd_data[i], model_rd(rd_addr[i]));
        check("rd_data_reg",   bus_r.rd_data[i], exp_reg[i]);
        check("rd_ready_comb", 32'(bus_c.rd_ready[i]), 32'(model_rdy(rd_addr[i])));
        check("rd_ready_reg",  32'(bus_r.rd_ready[i]), 32'(model_rdy(rd_addr[i])));
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #2;
    rst = 1'b0; wr_en = '0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p] = 1'b1; wr_addr[p] = a; wr_data[p] = d;
  endtask

  task automatic iss(input logic [4:0] a);
    iss_en = 1'b1; iss_rd = a;
  endtask

  function automatic logic [4:0] small_addr();
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) begin regs[r] = '0; pend[r] = 1'b0; end
    rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    chk_en = 1'b1;

    // 1: after reset every register reads zero and is ready.
    for (int a = 1; a < 32; a++) begin
      next();
      rd_addr[0] = 5'(a); rd_addr[1] = 5'(32 - a);
      @(negedge clk);
      check("t1_rd_reg", bus_r.rd_data[0], 32'd0);
      check("t1_ready",  32'(bus_r.rd_ready[0]), 32'd1);
    end

    // 2: write x5 and read it in the same cycle.
    next(); wr(0, 5'd5, 32'hDEADBEEF); rd_addr[0] = 5'd5;
    @(negedge clk); check("t2_bypass_comb", bus_c.rd_data[0], 32'hDEADBEEF);
    next();
    @(negedge clk); check("t2_bypass_reg", bus_r.rd_data[0], 32'hDEADBEEF);

    // 3: x0 ignores writes and issue.
    next(); wr(0, 5'd0, 32'h1234); iss(5'd0); rd_addr[0] = 5'd0;
    @(negedge clk); check("t3_x0_comb", bus_c.rd_data[0], 32'd0);
    check("t3_x0_ready", 32'(bus_c.rd_ready[0]), 32'd1);
    next();
    @(negedge clk); check("t3_x0_reg", bus_r.rd_data[0], 32'd0);
    check("t3_x0_ready_next", 32'(bus_r.rd_ready[0]), 32'd1);

    // 4: both ports write x7, the higher port wins.
    next(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd_addr[1] = 5'd7;
    @(negedge clk); check("t4_collide_comb", bus_c.rd_data[1], 32'h22);
    next();
    @(negedge clk); check("t4_collide_arr", bus_c.rd_data[1], 32'h22);
    check("t4_collide_reg", bus_r.rd_data[1], 32'h22);

    // 5: issue x9, then writeback and re-issue together, then final writeback.
    next(); iss(5'd9); rd_addr[0] = 5'd9;
    @(negedge clk); check("t5_ready_before", 32'(bus_c.rd_ready[0]), 32'd1);
    next();
    @(negedge clk); check("t5_pending", 32'(bus_c.rd_ready[0]), 32'd0);
    next(); wr(0, 5'd9, 32'h55); iss(5'd9);
    @(negedge clk); check("t5_wb_ready", 32'(bus_c.rd_ready[0]), 32'd1);
    check("t5_wb_data", bus_c.rd_data[0], 32'h55);
    next();
    @(negedge clk); check("t5_still_pending", 32'(bus_c.rd_ready[0]), 32'd0);
    check("t5_data_55", bus_r.rd_data[0], 32'h55);
    next(); wr(1, 5'd9, 32'h66);
    next();
    @(negedge clk); check("t5_ready_after", 32'(bus_c.rd_ready[0]), 32'd1);
    check("t5_data_66", bus_c.rd_data[0], 32'h66);

    // 6: flush beats a same-cycle issue and clears older pending bits.
    next(); iss(5'd3);
    next(); iss(5'd4); rd_addr[0] = 5'd3;
    @(negedge clk); check("t6_x3_pending", 32'(bus_c.rd_ready[0]), 32'd0);
    next(); flush = 1'b1; iss(5'd6);
    next(); rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
    @(negedge clk); check("t6_x3_ready", 32'(bus_c.rd_ready[0]), 32'd1);
    check("t6_x4_ready", 32'(bus_c.rd_ready[1]), 32'd1);
    next(); rd_addr[0] = 5'd6;
    @(negedge clk); check("t6_x6_ready", 32'(bus_c.rd_ready[0]), 32'd1);

    // Reset in the middle of a write to x8 wins.
    next(); wr(0, 5'd8, 32'h77); iss(5'd8);
    next(); rst = 1'b1; wr(0, 5'd8, 32'hFF); rd_addr[0] = 5'd8;
    next(); rd_addr[0] = 5'd8;
    @(negedge clk); check("t6_rst_comb", bus_c.rd_data[0], 32'd0);
    check("t6_rst_reg", bus_r.rd_data[0], 32'd0);
    check("t6_rst_ready", 32'(bus_c.rd_ready[0]), 32'd1);
    next();
    @(negedge clk); check("t6_rst_reg_next", bus_r.rd_data[0], 32'd0);

    // Randomized traffic, concentrated on a few registers to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      next();
      rst = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < 2; p++) begin
        wr_en[p]   = 1'($urandom_range(0, 1));
        wr_addr[p] = small_addr();
        wr_data[p] = $urandom;
      end
      iss_en  = 1'($urandom_range(0, 1));
      iss_rd  = small_addr();
      flush   = ($urandom_range(0, 15) == 0);
      rd_addr[0] = small_addr();
      rd_addr[1] = small_addr();
    end
    next();
    @(negedge clk);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
